// File: rtl/bus_arbiter_nx1.sv
// bus_arbiter_nx1: N-master to 1-slave round-robin bus arbiter with atomic lock.
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_bus_en/i_wr_en/i_atomic [N]           per-master request, direction, lock
//   i_wr_data/i_addr [N*XLEN], i_byte_en [N*4]  per-master packed fields
//   o_ack [N]              one-hot ack to the granted master
//   o_rd_data [XLEN]       slave read data broadcast
//   i_ack, i_rd_data       slave ack pulse and read data
//   o_bus_en..o_atomic     granted master's fields, zero unless transferring
//   o_id [IDW]             granted master index
module bus_arbiter_nx1 #(
    parameter int N_MASTERS    = 2,
    parameter int XLEN         = 32,
    parameter int LOCK_TIMEOUT = 64,
    localparam int IDW         = $clog2(N_MASTERS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_MASTERS-1:0]      i_bus_en,
    input  logic [N_MASTERS-1:0]      i_wr_en,
    input  logic [N_MASTERS*XLEN-1:0] i_wr_data,
    input  logic [N_MASTERS*XLEN-1:0] i_addr,
    input  logic [N_MASTERS*4-1:0]    i_byte_en,
    input  logic [N_MASTERS-1:0]      i_atomic,
    output logic [N_MASTERS-1:0]      o_ack,
    output logic [XLEN-1:0]           o_rd_data,
    input  logic                      i_ack,
    input  logic [XLEN-1:0]           i_rd_data,
    output logic                      o_bus_en,
    output logic                      o_wr_en,
    output logic [XLEN-1:0]           o_wr_data,
    output logic [XLEN-1:0]           o_addr,
    output logic [3:0]                o_byte_en,
    output logic                      o_atomic,
    output logic [IDW-1:0]            o_id
);

    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;

    state_t         state, state_d;
    logic [IDW-1:0] grant, grant_d;
    logic [IDW-1:0] rr_ptr, rr_d;
    logic [CW-1:0]  lock_cnt, lock_cnt_d;
    logic [IDW-1:0] grant_nxt;
    logic           busy;

    logic [XLEN-1:0] wdata_a [N_MASTERS];
    logic [XLEN-1:0] addr_a  [N_MASTERS];
    logic [3:0]      be_a    [N_MASTERS];

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
        assign wdata_a[k] = i_wr_data[k*XLEN +: XLEN];
        assign addr_a[k]  = i_addr[k*XLEN +: XLEN];
        assign be_a[k]    = i_byte_en[k*4 +: 4];
    end

    // First requester at or after ptr, wrapping N-1 -> 0. Scanning from the
    // farthest offset down lets the nearest requester overwrite the result.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [N_MASTERS-1:0] req,
        input logic [IDW-1:0]       ptr
    );
        logic [IDW-1:0] idx;
        rr_pick = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr) + i) % N_MASTERS);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign grant_nxt = (grant == IDW'(N_MASTERS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            rr_ptr   <= rr_d;
            lock_cnt <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        grant_d    = grant;
        rr_d       = rr_ptr;
        lock_cnt_d = lock_cnt;
        unique case (state)
            IDLE: begin
                if (|i_bus_en) begin
                    grant_d = rr_pick(i_bus_en, rr_ptr);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A completed ack wins over a same-cycle request drop.
                if (i_ack) begin
                    rr_d       = grant_nxt;
                    lock_cnt_d = '0;
                    state_d    = i_atomic[grant] ? LOCKED : IDLE;
                end else if (!i_bus_en[grant]) begin
                    rr_d    = grant_nxt;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (i_bus_en[grant]) begin
                    lock_cnt_d = '0;
                    state_d    = BUSY;
                end else if (!i_atomic[grant]) begin
                    state_d = IDLE;
                end else if (lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state == BUSY);
    assign o_bus_en  = busy & i_bus_en[grant];
    assign o_wr_en   = busy & i_wr_en[grant];
    assign o_atomic  = busy & i_atomic[grant];
    assign o_wr_data = busy ? wdata_a[grant] : '0;
    assign o_addr    = busy ? addr_a[grant] : '0;
    assign o_byte_en = busy ? be_a[grant] : '0;
    assign o_id      = grant;
    assign o_rd_data = i_rd_data;

    always_comb begin
        o_ack = '0;
        if (busy && i_ack) o_ack[grant] = 1'b1;
    end

endmodule

// File: tb/tb_bus_arbiter_nx1.sv
// tb_bus_arbiter_nx1: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level arbiter model.
module tb_bus_arbiter_nx1;

    localparam int N    = 3;
    localparam int XLEN = 32;
    localparam int LT   = 4;
    localparam int IDW  = $clog2(N);

    localparam int M_FREE = 0;
    localparam int M_XFER = 1;
    localparam int M_HOLD = 2;

    logic              i_clk;
    logic              i_rst;
    logic [N-1:0]      i_bus_en;
    logic [N-1:0]      i_wr_en;
    logic [N*XLEN-1:0] i_wr_data;
    logic [N*XLEN-1:0] i_addr;
    logic [N*4-1:0]    i_byte_en;
    logic [N-1:0]      i_atomic;
    logic [N-1:0]      o_ack;
    logic [XLEN-1:0]   o_rd_data;
    logic              i_ack;
    logic [XLEN-1:0]   i_rd_data;
    logic              o_bus_en;
    logic              o_wr_en;
    logic [XLEN-1:0]   o_wr_data;
    logic [XLEN-1:0]   o_addr;
    logic [3:0]        o_byte_en;
    logic              o_atomic;
    logic [IDW-1:0]    o_id;

    int checks = 0;
    int failures = 0;

    bus_arbiter_nx1 #(
        .N_MASTERS(N), .XLEN(XLEN), .LOCK_TIMEOUT(LT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_bus_en(i_bus_en), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .i_addr(i_addr),
        .i_byte_en(i_byte_en), .i_atomic(i_atomic),
        .o_ack(o_ack), .o_rd_data(o_rd_data),
        .i_ack(i_ack), .i_rd_data(i_rd_data),
        .o_bus_en(o_bus_en), .o_wr_en(o_wr_en),
        .o_wr_data(o_wr_data), .o_addr(o_addr),
        .o_byte_en(o_byte_en), .o_atomic(o_atomic),
        .o_id(o_id)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, whether a transfer is
    // open or a lock is merely held, and where fairness resumes.
    int m_mode = M_FREE;
    int m_owner = 0;
    int m_next = 0;
    int m_idle = 0;

    function automatic int first_req(input logic [N-1:0] req, input int from);
        for (int d = 0; d < N; d++)
            if (req[(from + d) % N]) return (from + d) % N;
        return 0;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_mode  <= M_FREE;
            m_owner <= 0;
            m_next  <= 0;
            m_idle  <= 0;
        end else if (m_mode == M_FREE) begin
            if (i_bus_en != '0) begin
                m_owner <= first_req(i_bus_en, m_next);
                m_mode  <= M_XFER;
            end
        end else if (m_mode == M_XFER) begin
            if (i_ack || !i_bus_en[m_owner]) begin
                m_next <= (m_owner + 1) % N;
                m_idle <= 0;
                m_mode <= (i_ack && i_atomic[m_owner]) ? M_HOLD : M_FREE;
            end
        end else begin
            if (i_bus_en[m_owner]) begin
                m_mode <= M_XFER;
                m_idle <= 0;
            end else if (!i_atomic[m_owner] || m_idle + 1 >= LT) begin
                m_mode <= M_FREE;
            end else begin
                m_idle <= m_idle + 1;
            end
        end
    end

    logic [N-1:0] exp_ack;
    logic         xfer;

    always @(negedge i_clk) begin
        xfer = (m_mode == M_XFER);
        exp_ack = '0;
        if (xfer && i_ack) exp_ack[m_owner] = 1'b1;
        chk("m_id", 64'(o_id), 64'(m_owner));
        chk("m_ack", 64'(o_ack), 64'(exp_ack));
        chk("m_bus_en", 64'(o_bus_en), 64'(xfer && i_bus_en[m_owner]));
        chk("m_wr_en", 64'(o_wr_en), 64'(xfer && i_wr_en[m_owner]));
        chk("m_atomic", 64'(o_atomic), 64'(xfer && i_atomic[m_owner]));
        chk("m_wr_data", 64'(o_wr_data),
            xfer ? 64'(XLEN'(i_wr_data >> (m_owner * XLEN))) : 64'd0);
        chk("m_addr", 64'(o_addr),
            xfer ? 64'(XLEN'(i_addr >> (m_owner * XLEN))) : 64'd0);
        chk("m_byte_en", 64'(o_byte_en),
            xfer ? 64'(4'(i_byte_en >> (m_owner * 4))) : 64'd0);
        chk("m_rd_data", 64'(o_rd_data), 64'(i_rd_data));
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_in();
        i_bus_en = '0;
        i_wr_en = '0;
        i_wr_data = '0;
        i_addr = '0;
        i_byte_en = '0;
        i_atomic = '0;
        i_ack = 1'b0;
        i_rd_data = '0;
    endtask

    task automatic do_reset();
        clear_in();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_bus(input int budget, output int n);
        n = 0;
        while (o_bus_en !== 1'b1 && n < budget) begin
            tick();
            #1;
            n++;
        end
        chk("grant_wait", 64'(o_bus_en), 64'd1);
    endtask

    task automatic finish_xfer();
        i_ack = 1'b1;
        tick();
        clear_in();
        #1;
    endtask

    logic [N-1:0] req, atom, acked;
    logic         ack_now;

    initial begin
        int n;
        int exp_rr[6];
        exp_rr = '{0, 1, 2, 0, 1, 2};
        clear_in();
        i_rst = 1'b0;
        #1;
        i_rst = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_bus_en", 64'(o_bus_en), 64'd0);
        chk("rst_id", 64'(o_id), 64'd0);
        i_rst = 1'b0;

        // Single request: one-cycle arbitration latency, ack at c3
        tick();
        i_bus_en = 3'b010;
        i_addr[XLEN +: XLEN] = 32'h100;
        #1;
        chk("t1_c0_bus_en", 64'(o_bus_en), 64'd0);
        tick();
        #1;
        chk("t1_c1_bus_en", 64'(o_bus_en), 64'd1);
        chk("t1_c1_id", 64'(o_id), 64'd1);
        chk("t1_c1_addr", 64'(o_addr), 64'h100);
        tick();
        #1;
        tick();
        i_ack = 1'b1;
        #1;
        chk("t1_c3_ack", 64'(o_ack), 64'b010);
        tick();
        clear_in();
        #1;
        chk("t1_c4_bus_en", 64'(o_bus_en), 64'd0);

        // Everyone requesting: strict rotation from m0
        do_reset();
        i_bus_en = 3'b111;
        #1;
        for (int t = 0; t < 6; t++) begin
            wait_bus(8, n);
            chk("t2_rr_order", 64'(o_id), 64'(exp_rr[t]));
            i_ack = 1'b1;
            tick();
            i_ack = 1'b0;
            #1;
        end
        clear_in();

        // Lock keeps m0 ahead of m1 for its follow-up transfer
        do_reset();
        i_bus_en = 3'b011;
        i_atomic = 3'b001;
        #1;
        wait_bus(8, n);
        chk("t3_lr_id", 64'(o_id), 64'd0);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        i_bus_en = 3'b010;
        #1;
        chk("t3_locked0", 64'(o_bus_en), 64'd0);
        tick();
        #1;
        chk("t3_locked1", 64'(o_bus_en), 64'd0);
        tick();
        i_bus_en = 3'b011;
        #1;
        wait_bus(8, n);
        chk("t3_sc_lat", 64'(n), 64'd1);
        chk("t3_sc_id", 64'(o_id), 64'd0);
        i_atomic = 3'b000;
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        i_bus_en = 3'b010;
        #1;
        wait_bus(8, n);
        chk("t3_m1_id", 64'(o_id), 64'd1);
        finish_xfer();

        // Idle lock is forcibly released after LT cycles
        do_reset();
        i_bus_en = 3'b011;
        i_atomic = 3'b001;
        #1;
        wait_bus(8, n);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        i_bus_en = 3'b010;
        #1;
        wait_bus(12, n);
        chk("t4_timeout_wait", 64'(n), 64'd5);
        chk("t4_m1_id", 64'(o_id), 64'd1);
        finish_xfer();

        // Async reset mid-transfer, stray ack, restart at m0
        do_reset();
        i_bus_en = 3'b100;
        i_addr[2*XLEN +: XLEN] = 32'hdead_beef;
        #1;
        wait_bus(8, n);
        chk("t5_id", 64'(o_id), 64'd2);
        i_ack = 1'b1;
        i_rst = 1'b1;
        #1;
        chk("t5_rst_bus_en", 64'(o_bus_en), 64'd0);
        chk("t5_rst_id", 64'(o_id), 64'd0);
        chk("t5_rst_addr", 64'(o_addr), 64'd0);
        chk("t5_rst_ack", 64'(o_ack), 64'd0);
        tick();
        i_rst = 1'b0;
        i_bus_en = '0;
        #1;
        chk("t5_stray_ack", 64'(o_ack), 64'd0);
        tick();
        i_ack = 1'b0;
        i_bus_en = 3'b111;
        #1;
        wait_bus(8, n);
        chk("t5_restart_id", 64'(o_id), 64'd0);
        finish_xfer();

        // Request withdrawn before ack
        i_bus_en = 3'b010;
        #1;
        wait_bus(8, n);
        chk("t6_id", 64'(o_id), 64'd1);
        i_bus_en = 3'b001;
        #1;
        chk("t6_drop_bus_en", 64'(o_bus_en), 64'd0);
        tick();
        #1;
        chk("t6_idle_bus_en", 64'(o_bus_en), 64'd0);
        wait_bus(8, n);
        chk("t6_m0_id", 64'(o_id), 64'd0);
        finish_xfer();

        // Randomized protocol-following traffic
        do_reset();
        req = '0;
        atom = '0;
        acked = '0;
        for (int c = 0; c < 3000; c++) begin
            ack_now = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < N; k++) begin
                if (acked[k])
                    req[k] = 1'($urandom_range(0, 1));
                else if (req[k]) begin
                    if (!ack_now && $urandom_range(0, 39) == 0)
                        req[k] = 1'b0;
                end else
                    req[k] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 7) == 0) atom[k] = ~atom[k];
                i_wr_data[k*XLEN +: XLEN] = $urandom;
                i_addr[k*XLEN +: XLEN] = $urandom;
            end
            i_bus_en = req;
            i_atomic = atom;
            i_ack = ack_now;
            i_wr_en = N'($urandom);
            i_byte_en = (N*4)'($urandom);
            i_rd_data = $urandom;
            #3;
            acked = o_ack;
            tick();
        end

        clear_in();
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
